instruction_fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: PC register, next-PC select, instruction memory, IF/ID register.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/instruction_fetch_stage_if.sv | 50 +++++
 rtl/instruction_memory.sv | 25 ++
 rtl/instruction_fetch_stage.sv | 112 +++++++++++
 tb/tb_instruction_fetch_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and encodings for the MIPS pipeline stages.
// Default widths are common to the IF stage, the ID stage and the debug unit.
package pipeline_pkg;

    localparam int DEF_PC_SZ       = 32;
    localparam int DEF_INST_SZ     = 32;
    localparam int DEF_MEM_ADDR_SZ = 10;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_OPCODE = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Control, program-load and IF/ID signals of the fetch stage.
// STEP_MODE_EN adds the single-step strobe i_step.
interface instruction_fetch_stage_if
    import pipeline_pkg::*;
#(
    parameter int PC_SZ       = DEF_PC_SZ,
    parameter int INST_SZ     = DEF_INST_SZ,
    parameter int MEM_ADDR_SZ = DEF_MEM_ADDR_SZ
) ();

`ifdef STEP_MODE_EN
    logic                   i_step;
`endif
    logic                   i_enable;
    logic                   i_stall_pc_HD;
    logic                   i_stall_if_id_HD;
    logic                   i_pc_src_D;
    logic                   i_jump_D;
    logic [PC_SZ-1:0]       i_branch_addr_D;
    logic [PC_SZ-1:0]       i_jump_addr_D;
    logic                   i_inst_wr_en;
    logic [MEM_ADDR_SZ-1:0] i_inst_wr_addr;
    logic [INST_SZ-1:0]     i_inst_wr_data;
    logic [PC_SZ-1:0]       o_pc;
    logic [PC_SZ-1:0]       o_pc_plus4_IF_ID;
    logic [INST_SZ-1:0]     o_instr_IF_ID;
    logic                   o_valid_IF_ID;
    logic                   o_halt;

    modport master (
`ifdef STEP_MODE_EN
        output i_step,
`endif
        output i_enable, i_stall_pc_HD, i_stall_if_id_HD, i_pc_src_D, i_jump_D,
        output i_branch_addr_D, i_jump_addr_D,
        output i_inst_wr_en, i_inst_wr_addr, i_inst_wr_data,
        input  o_pc, o_pc_plus4_IF_ID, o_instr_IF_ID, o_valid_IF_ID, o_halt
    );

    modport slave (
`ifdef STEP_MODE_EN
        input  i_step,
`endif
        input  i_enable, i_stall_pc_HD, i_stall_if_id_HD, i_pc_src_D, i_jump_D,
        input  i_branch_addr_D, i_jump_addr_D,
        input  i_inst_wr_en, i_inst_wr_addr, i_inst_wr_data,
        output o_pc, o_pc_plus4_IF_ID, o_instr_IF_ID, o_valid_IF_ID, o_halt
    );

endinterface

// File: rtl/instruction_memory.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded program survives pipeline resets.
module instruction_memory #(
    parameter int MEM_ADDR_SZ = 10,
    parameter int INST_SZ     = 32
) (
    input  logic                   i_clk,
    input  logic                   i_wr_en,
    input  logic [MEM_ADDR_SZ-1:0] i_wr_addr,
    input  logic [INST_SZ-1:0]     i_wr_data,
    input  logic [MEM_ADDR_SZ-1:0] i_rd_addr,
    output logic [INST_SZ-1:0]     o_rd_data
);

    logic [INST_SZ-1:0] mem [2**MEM_ADDR_SZ];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, next-PC select, instruction memory and IF/ID register with HALT freeze.
// Optional STEP_MODE_EN: i_step advances the stage one cycle while i_enable is low.
module instruction_fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                 PC_SZ       = DEF_PC_SZ,
    parameter int                 INST_SZ     = DEF_INST_SZ,
    parameter int                 MEM_ADDR_SZ = DEF_MEM_ADDR_SZ,
    parameter logic [INST_SZ-1:0] HALT_OPCODE = INST_SZ'(DEF_HALT_OPCODE)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    instruction_fetch_stage_if.slave  bus
);

    fetch_state_t       state, state_nxt;
    logic [PC_SZ-1:0]   pc, pc_nxt, pc_plus4;
    logic [PC_SZ-1:0]   pc_plus4_if_id, pc_plus4_if_id_nxt;
    logic [INST_SZ-1:0] instr_fetch, instr_if_id, instr_if_id_nxt;
    logic               valid_if_id, valid_if_id_nxt;
    logic [PC_SZ-1:0]   branch_tgt, jump_tgt;
    logic               advance, redirect, if_id_load, halt_hit;

    instruction_memory #(
        .MEM_ADDR_SZ (MEM_ADDR_SZ),
        .INST_SZ     (INST_SZ)
    ) u_imem (
        .i_clk     (i_clk),
        .i_wr_en   (bus.i_inst_wr_en),
        .i_wr_addr (bus.i_inst_wr_addr),
        .i_wr_data (bus.i_inst_wr_data),
        .i_rd_addr (pc[MEM_ADDR_SZ+1:2]),
        .o_rd_data (instr_fetch)
    );

`ifdef STEP_MODE_EN
    assign advance = bus.i_enable | bus.i_step;
`else
    assign advance = bus.i_enable;
`endif

    assign pc_plus4   = pc + PC_SZ'(4);
    assign branch_tgt = bus.i_branch_addr_D & ~PC_SZ'(3);
    assign jump_tgt   = bus.i_jump_addr_D & ~PC_SZ'(3);
    assign redirect   = bus.i_jump_D | bus.i_pc_src_D;
    assign if_id_load = !bus.i_stall_if_id_HD && !redirect;
    // HALT only counts once it actually lands in IF/ID; a stalled or flushed HALT is refetched.
    assign halt_hit   = if_id_load && (instr_fetch == HALT_OPCODE);

    always_comb begin
        state_nxt          = state;
        pc_nxt             = pc;
        pc_plus4_if_id_nxt = pc_plus4_if_id;
        instr_if_id_nxt    = instr_if_id;
        valid_if_id_nxt    = valid_if_id;
        if (advance) begin
            case (state)
                RUN: begin
                    if (bus.i_stall_pc_HD || halt_hit) pc_nxt = pc;
                    else if (bus.i_jump_D)             pc_nxt = jump_tgt;
                    else if (bus.i_pc_src_D)           pc_nxt = branch_tgt;
                    else                               pc_nxt = pc_plus4;

                    if (bus.i_stall_if_id_HD) begin
                        valid_if_id_nxt = valid_if_id;
                    end else if (redirect) begin
                        instr_if_id_nxt    = INST_SZ'(NOP_INSTR);
                        pc_plus4_if_id_nxt = '0;
                        valid_if_id_nxt    = 1'b0;
                    end else begin
                        instr_if_id_nxt    = instr_fetch;
                        pc_plus4_if_id_nxt = pc_plus4;
                        valid_if_id_nxt    = 1'b1;
                    end

                    if (halt_hit) state_nxt = HALTED;
                end
                HALTED: begin
                    if (!bus.i_stall_if_id_HD) begin
                        instr_if_id_nxt    = INST_SZ'(NOP_INSTR);
                        pc_plus4_if_id_nxt = '0;
                        valid_if_id_nxt    = 1'b0;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= RUN;
            pc             <= '0;
            pc_plus4_if_id <= '0;
            instr_if_id    <= INST_SZ'(NOP_INSTR);
            valid_if_id    <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            pc_plus4_if_id <= pc_plus4_if_id_nxt;
            instr_if_id    <= instr_if_id_nxt;
            valid_if_id    <= valid_if_id_nxt;
        end
    end

    assign bus.o_pc             = pc;
    assign bus.o_pc_plus4_IF_ID = pc_plus4_if_id;
    assign bus.o_instr_IF_ID    = instr_if_id;
    assign bus.o_valid_IF_ID    = valid_if_id;
    assign bus.o_halt           = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: stimulus pushes hand-computed post-edge state,
// a monitor pops and compares after every rising edge. Step pulses exercised under STEP_MODE_EN.
module tb_instruction_fetch_stage;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_stage_if #(.PC_SZ(32), .INST_SZ(32), .MEM_ADDR_SZ(10)) bus ();

    instruction_fetch_stage #(
        .PC_SZ       (32),
        .INST_SZ     (32),
        .MEM_ADDR_SZ (10),
        .HALT_OPCODE (32'hFFFF_FFFF)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        bit          chk;
        string       name;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

`ifdef STEP_MODE_EN
    logic step_r = 1'b0;
    assign bus.i_step = step_r;
`endif

    initial begin
        bus.i_enable         = 1'b0;
        bus.i_stall_pc_HD    = 1'b0;
        bus.i_stall_if_id_HD = 1'b0;
        bus.i_pc_src_D       = 1'b0;
        bus.i_jump_D         = 1'b0;
        bus.i_branch_addr_D  = '0;
        bus.i_jump_addr_D    = '0;
        bus.i_inst_wr_en     = 1'b0;
        bus.i_inst_wr_addr   = '0;
        bus.i_inst_wr_data   = '0;
    end

    task automatic push_exp(input bit chk, input string name, input logic [31:0] e_pc, e_pc4,
                            e_ins, input logic e_v, e_h);
        exp_t e;
        e.chk = chk; e.name = name; e.pc = e_pc; e.pc4 = e_pc4;
        e.instr = e_ins; e.valid = e_v; e.halt = e_h;
        q.push_back(e);
    endtask

    // One clock of stimulus plus the state expected right after that edge.
    task automatic cyc(input string name, input logic r, en, spc, sif, src, jmp,
                       input logic [31:0] ba, ja,
                       input logic [31:0] e_pc, e_pc4, e_ins, input logic e_v, e_h);
        @(negedge clk);
        rst = r;
        bus.i_enable = en; bus.i_stall_pc_HD = spc; bus.i_stall_if_id_HD = sif;
        bus.i_pc_src_D = src; bus.i_jump_D = jmp;
        bus.i_branch_addr_D = ba; bus.i_jump_addr_D = ja;
        bus.i_inst_wr_en = 1'b0;
`ifdef STEP_MODE_EN
        step_r = 1'b0;
`endif
        push_exp(1'b1, name, e_pc, e_pc4, e_ins, e_v, e_h);
        @(posedge clk);
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        @(negedge clk);
        rst = 1'b0;
        bus.i_enable = 1'b0; bus.i_stall_pc_HD = 1'b0; bus.i_stall_if_id_HD = 1'b0;
        bus.i_pc_src_D = 1'b0; bus.i_jump_D = 1'b0;
        bus.i_inst_wr_en = 1'b1; bus.i_inst_wr_addr = 10'(addr); bus.i_inst_wr_data = data;
`ifdef STEP_MODE_EN
        step_r = 1'b0;
`endif
        push_exp(1'b0, "load", '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
    endtask

`ifdef STEP_MODE_EN
    task automatic stp(input string name, input logic s,
                       input logic [31:0] e_pc, e_pc4, e_ins, input logic e_v);
        @(negedge clk);
        rst = 1'b0;
        bus.i_enable = 1'b0; bus.i_stall_pc_HD = 1'b0; bus.i_stall_if_id_HD = 1'b0;
        bus.i_pc_src_D = 1'b0; bus.i_jump_D = 1'b0; bus.i_inst_wr_en = 1'b0;
        step_r = s;
        push_exp(1'b1, name, e_pc, e_pc4, e_ins, e_v, 1'b0);
        @(posedge clk);
    endtask
`endif

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
                n_chk++;
                if (bus.o_pc === e.pc && bus.o_pc_plus4_IF_ID === e.pc4 &&
                    bus.o_instr_IF_ID === e.instr && bus.o_valid_IF_ID === e.valid &&
                    bus.o_halt === e.halt) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got pc=%h pc4=%h instr=%h v=%b h=%b, want pc=%h pc4=%h instr=%h v=%b h=%b",
                             e.name, bus.o_pc, bus.o_pc_plus4_IF_ID, bus.o_instr_IF_ID,
                             bus.o_valid_IF_ID, bus.o_halt, e.pc, e.pc4, e.instr, e.valid, e.halt);
                end
            end
        end
    end

    initial begin
        //   name            r en spc sif src jmp ba          ja            pc           pc4          instr      v  h
        cyc("reset",         1, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,       32'h0,       32'h0,     0, 0);
        wr(0, 32'h11); wr(1, 32'h22); wr(2, 32'h33); wr(3, 32'h44); wr(4, 32'h55);
        wr(16, 32'h66); wr(33, 32'h77); wr(34, 32'h88); wr(1023, 32'h99);
        cyc("idle_hold",     0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,       32'h0,       32'h0,     0, 0);
        cyc("fetch_pc0",     0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h4,       32'h4,       32'h11,    1, 0);
        cyc("fetch_pc4",     0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h8,       32'h8,       32'h22,    1, 0);
        cyc("stall_1",       0, 1, 1, 1, 0, 0, 32'h0,       32'h0,        32'h8,       32'h8,       32'h22,    1, 0);
        cyc("stall_2",       0, 1, 1, 1, 0, 0, 32'h0,       32'h0,        32'h8,       32'h8,       32'h22,    1, 0);
        cyc("resume",        0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'hC,       32'hC,       32'h33,    1, 0);
        cyc("fetch_pc12",    0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h10,      32'h10,      32'h44,    1, 0);
        cyc("branch",        0, 1, 0, 0, 1, 0, 32'h40,      32'h0,        32'h40,      32'h0,       32'h0,     0, 0);
        cyc("stall_redir",   0, 1, 1, 1, 1, 0, 32'h80,      32'h0,        32'h40,      32'h0,       32'h0,     0, 0);
        cyc("fetch_br_tgt",  0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h44,      32'h44,      32'h66,    1, 0);
        cyc("jump_over_br",  0, 1, 0, 0, 1, 1, 32'h40,      32'h80,       32'h80,      32'h0,       32'h0,     0, 0);
        cyc("branch_align",  0, 1, 0, 0, 1, 0, 32'h43,      32'h0,        32'h40,      32'h0,       32'h0,     0, 0);
        cyc("jump_align",    0, 1, 0, 0, 0, 1, 32'h0,       32'h87,       32'h84,      32'h0,       32'h0,     0, 0);
        cyc("stall_ifid",    0, 1, 0, 1, 0, 0, 32'h0,       32'h0,        32'h88,      32'h0,       32'h0,     0, 0);
        cyc("stall_pc",      0, 1, 1, 0, 0, 0, 32'h0,       32'h0,        32'h88,      32'h8C,      32'h88,    1, 0);
        cyc("after_stallpc", 0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h8C,      32'h8C,      32'h88,    1, 0);
        cyc("disabled_hold", 0, 0, 1, 0, 1, 0, 32'h100,     32'h0,        32'h8C,      32'h8C,      32'h88,    1, 0);
        cyc("jump_top",      0, 1, 0, 0, 0, 1, 32'h0,       32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,      32'h0,     0, 0);
        cyc("pc_wrap",       0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,       32'h0,       32'h99,    1, 0);
        cyc("reset_midrun",  1, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,       32'h0,       32'h0,     0, 0);
        wr(2, HALT);
        cyc("h_fetch0",      0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h4,       32'h4,       32'h11,    1, 0);
        cyc("h_fetch4",      0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h8,       32'h8,       32'h22,    1, 0);
        cyc("halt_stalled",  0, 1, 0, 1, 0, 0, 32'h0,       32'h0,        32'hC,       32'h8,       32'h22,    1, 0);
        cyc("jump_to_halt",  0, 1, 0, 0, 0, 1, 32'h0,       32'h8,        32'h8,       32'h0,       32'h0,     0, 0);
        cyc("halt_enter",    0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h8,       32'hC,       HALT,      1, 1);
        cyc("halted_nop",    0, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h8,       32'h0,       32'h0,     0, 1);
        cyc("halted_jump",   0, 1, 0, 0, 0, 1, 32'h0,       32'h40,       32'h8,       32'h0,       32'h0,     0, 1);
        cyc("reset_halted",  1, 1, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,       32'h0,       32'h0,     0, 0);
`ifdef STEP_MODE_EN
        wr(2, 32'h33);
        stp("step_1",    1, 32'h4,  32'h4,  32'h11, 1);
        stp("step_gap1", 0, 32'h4,  32'h4,  32'h11, 1);
        stp("step_gap2", 0, 32'h4,  32'h4,  32'h11, 1);
        stp("step_2",    1, 32'h8,  32'h8,  32'h22, 1);
        stp("step_gap3", 0, 32'h8,  32'h8,  32'h22, 1);
        stp("step_3",    1, 32'hC,  32'hC,  32'h33, 1);
        stp("step_gap4", 0, 32'hC,  32'hC,  32'h33, 1);
        stp("step_held1",1, 32'h10, 32'h10, 32'h44, 1);
        stp("step_held2",1, 32'h14, 32'h14, 32'h55, 1);
        stp("step_off",  0, 32'h14, 32'h14, 32'h55, 1);
`endif
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
